xif_mem_responder: RTL and testbench

- Core-side responder for the CORE-V-XIF memory and memory-result interfaces; serves load/store requests issued by the rvfpm coprocessor.
- Validates each request and answers with mem_resp in the handshake cycle.
- Forwards valid requests to a simple req/gnt/rvalid data-RAM port and returns in-order mem_result, tagged with the original instruction ID.
- Sits in the core/testbench wrapper between rvfpm's xif_mem/xif_mem_result ports and the data memory.

---
 rtl/xif_mem_responder_pkg.sv | 34 +++
 rtl/xif_mem_responder_if.sv | 46 ++++
 rtl/xif_mem_responder_chk.sv | 24 ++
 rtl/xif_mem_responder_id_fifo.sv | 60 ++++++
 rtl/xif_mem_responder.sv | 151 +++++++++++++++
 tb/tb_xif_mem_responder.sv | 209 ++++++++++++++++++++
 6 files changed

// File: rtl/xif_mem_responder_pkg.sv
// Shared types and exception causes for the rvfpm memory responder.
// Optional build macro: RVFPM_MEM_RANGE_CHECK_EN (consumed by xif_mem_responder).
package pa_rvfpm;

  localparam int unsigned X_ID_WIDTH = 4;
  localparam int unsigned FLEN       = 32;

  localparam logic [5:0] EXC_ILLEGAL     = 6'd2;
  localparam logic [5:0] EXC_LD_MISALIGN = 6'd4;
  localparam logic [5:0] EXC_LD_FAULT    = 6'd5;
  localparam logic [5:0] EXC_ST_MISALIGN = 6'd6;
  localparam logic [5:0] EXC_ST_FAULT    = 6'd7;

  typedef struct packed {
    logic [X_ID_WIDTH-1:0] id;
    logic                  we;
    logic [1:0]            offset;
    logic [2:0]            size;
  } mem_tag_t;

  // Move the addressed bytes down to bit 0 and zero-extend to the access size.
  function automatic logic [FLEN-1:0] align_load(input logic [FLEN-1:0] word,
                                                 input logic [1:0]      offset,
                                                 input logic [2:0]      size);
    logic [FLEN-1:0] shifted;
    shifted = word >> {offset, 3'b000};
    case (size)
      3'd0:    return FLEN'(shifted[7:0]);
      3'd1:    return FLEN'(shifted[15:0]);
      default: return shifted;
    endcase
  endfunction

endpackage

// File: rtl/xif_mem_responder_if.sv
// Request/response and backend RAM signal bundle around the memory responder.
interface xif_mem_responder_if #(
  parameter int unsigned X_ID_WIDTH  = 4,
  parameter int unsigned X_MEM_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH  = 32
);
  logic                     mem_valid;
  logic                     mem_ready;
  logic [X_ID_WIDTH-1:0]    mem_req_id;
  logic [ADDR_WIDTH-1:0]    mem_req_addr;
  logic                     mem_req_we;
  logic [2:0]               mem_req_size;
  logic [X_MEM_WIDTH/8-1:0] mem_req_be;
  logic [X_MEM_WIDTH-1:0]   mem_req_wdata;
  logic                     mem_resp_exc;
  logic [5:0]               mem_resp_exccode;
  logic                     mem_result_valid;
  logic [X_ID_WIDTH-1:0]    mem_result_id;
  logic [X_MEM_WIDTH-1:0]   mem_result_rdata;
  logic                     mem_result_err;
  logic                     ram_req;
  logic                     ram_gnt;
  logic [ADDR_WIDTH-1:0]    ram_addr;
  logic                     ram_we;
  logic [X_MEM_WIDTH/8-1:0] ram_be;
  logic [X_MEM_WIDTH-1:0]   ram_wdata;
  logic                     ram_rvalid;
  logic [X_MEM_WIDTH-1:0]   ram_rdata;
  logic                     ram_err;

  modport slave (
    input  mem_valid, mem_req_id, mem_req_addr, mem_req_we, mem_req_size,
           mem_req_be, mem_req_wdata, ram_gnt, ram_rvalid, ram_rdata, ram_err,
    output mem_ready, mem_resp_exc, mem_resp_exccode, mem_result_valid,
           mem_result_id, mem_result_rdata, mem_result_err, ram_req, ram_addr,
           ram_we, ram_be, ram_wdata
  );

  modport master (
    output mem_valid, mem_req_id, mem_req_addr, mem_req_we, mem_req_size,
           mem_req_be, mem_req_wdata, ram_gnt, ram_rvalid, ram_rdata, ram_err,
    input  mem_ready, mem_resp_exc, mem_resp_exccode, mem_result_valid,
           mem_result_id, mem_result_rdata, mem_result_err, ram_req, ram_addr,
           ram_we, ram_be, ram_wdata
  );
endinterface

// File: rtl/xif_mem_responder_chk.sv
// Runtime checks on tag FIFO usage and the stray-rvalid flag; no synthesizable logic.
module xif_mem_responder_chk (
  input logic ck,
  input logic rst_n,
  input logic push_i,
  input logic pop_i,
  input logic full_i,
  input logic empty_i,
  input logic stray_rvalid_i
);
  logic stray_prev_q;

  // The FIFO is never overrun/underrun and the stray flag never clears outside reset.
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      stray_prev_q <= 1'b0;
    end else begin
      stray_prev_q <= stray_rvalid_i;
      assert (!(push_i && full_i));
      assert (!(pop_i && empty_i));
      assert (!(stray_prev_q && !stray_rvalid_i));
    end
  end
endmodule

// File: rtl/xif_mem_responder_id_fifo.sv
// In-order tag FIFO: one entry per backend access still awaiting rvalid.
module xif_mem_id_fifo
  import pa_rvfpm::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic     ck,
  input  logic     rst_n,
  input  logic     push_i,
  input  mem_tag_t data_i,
  input  logic     pop_i,
  output mem_tag_t data_o,
  output logic     full_o,
  output logic     empty_o
);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  mem_tag_t          mem_q [DEPTH];
  logic [PTR_W-1:0]  wptr_q;
  logic [PTR_W-1:0]  rptr_q;
  logic [CNT_W-1:0]  cnt_q;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      return {PTR_W{1'b0}};
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  assign data_o  = mem_q[rptr_q];
  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == {CNT_W{1'b0}});

  // Storage, pointers and occupancy.
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wptr_q <= {PTR_W{1'b0}};
      rptr_q <= {PTR_W{1'b0}};
      cnt_q  <= {CNT_W{1'b0}};
    end else begin
      if (push_i) begin
        mem_q[wptr_q] <= data_i;
        wptr_q        <= ptr_inc(wptr_q);
      end
      if (pop_i) begin
        rptr_q <= ptr_inc(rptr_q);
      end
      case ({push_i, pop_i})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end
endmodule

// File: rtl/xif_mem_responder.sv
// CORE-V-XIF memory responder: validates rvfpm load/store requests, forwards them to a
// req/gnt/rvalid RAM port and returns in-order results. Macro RVFPM_MEM_RANGE_CHECK_EN
// enables the [ADDR_LO, ADDR_HI] access-fault check.
module xif_mem_responder
  import pa_rvfpm::*;
#(
  parameter int unsigned           X_ID_WIDTH      = pa_rvfpm::X_ID_WIDTH,
  parameter int unsigned           X_MEM_WIDTH     = pa_rvfpm::FLEN,
  parameter int unsigned           ADDR_WIDTH      = 32,
  parameter int unsigned           MAX_OUTSTANDING = 2,
  parameter logic [ADDR_WIDTH-1:0] ADDR_LO         = 32'h0000_0000,
  parameter logic [ADDR_WIDTH-1:0] ADDR_HI         = 32'h0000_FFFF
) (
  input logic               ck,
  input logic               rst_n,
  xif_mem_responder_if.slave bus
);
  logic     illegal_s;
  logic     misalign_s;
  logic     fault_s;
  logic     exc_s;
  logic [5:0] exccode_s;
  logic     full_s;
  logic     empty_s;
  logic     ram_req_s;
  logic     accept_s;
  logic     pop_s;
  mem_tag_t push_tag_s;
  mem_tag_t head_tag_s;

  logic                   result_valid_q, result_valid_d;
  logic [X_ID_WIDTH-1:0]  result_id_q,    result_id_d;
  logic [X_MEM_WIDTH-1:0] result_rdata_q, result_rdata_d;
  logic                   result_err_q,   result_err_d;
  logic                   stray_rvalid_q, stray_rvalid_d;

`ifdef RVFPM_MEM_RANGE_CHECK_EN
  logic [ADDR_WIDTH-1:0] rel_addr_s;
  logic [ADDR_WIDTH:0]   last_byte_s;
  // Wrapping subtraction folds the low and high bound into one unsigned compare.
  assign rel_addr_s  = bus.mem_req_addr - ADDR_LO;
  assign last_byte_s = {1'b0, bus.mem_req_addr}
                     + ((ADDR_WIDTH+1)'(1) << bus.mem_req_size) - (ADDR_WIDTH+1)'(1);
  assign fault_s     = (rel_addr_s > (ADDR_HI - ADDR_LO)) || (last_byte_s > {1'b0, ADDR_HI});
`else
  logic unused_range_s;
  assign unused_range_s = ^{ADDR_LO, ADDR_HI};
  assign fault_s        = 1'b0;
`endif

  // Request classification and exception cause, illegal > misaligned > fault.
  always_comb begin
    illegal_s = (bus.mem_req_size > 3'd2);
    case (bus.mem_req_size)
      3'd1:    misalign_s = bus.mem_req_addr[0];
      3'd2:    misalign_s = |bus.mem_req_addr[1:0];
      default: misalign_s = 1'b0;
    endcase
    exc_s = illegal_s || misalign_s || fault_s;
    if (illegal_s) begin
      exccode_s = EXC_ILLEGAL;
    end else if (misalign_s) begin
      exccode_s = bus.mem_req_we ? EXC_ST_MISALIGN : EXC_LD_MISALIGN;
    end else if (fault_s) begin
      exccode_s = bus.mem_req_we ? EXC_ST_FAULT : EXC_LD_FAULT;
    end else begin
      exccode_s = 6'd0;
    end
  end

  assign ram_req_s = bus.mem_valid && !exc_s && !full_s;
  assign accept_s  = ram_req_s && bus.ram_gnt;
  assign pop_s     = bus.ram_rvalid && !empty_s;

  assign bus.mem_ready        = exc_s ? bus.mem_valid : accept_s;
  assign bus.mem_resp_exc     = bus.mem_valid && exc_s;
  assign bus.mem_resp_exccode = bus.mem_resp_exc ? exccode_s : 6'd0;
  assign bus.ram_req          = ram_req_s;
  assign bus.ram_addr         = ram_req_s ? {bus.mem_req_addr[ADDR_WIDTH-1:2], 2'b00}
                                          : {ADDR_WIDTH{1'b0}};
  assign bus.ram_we           = ram_req_s && bus.mem_req_we;
  assign bus.ram_be           = ram_req_s ? bus.mem_req_be : {(X_MEM_WIDTH/8){1'b0}};
  assign bus.ram_wdata        = ram_req_s ? bus.mem_req_wdata : {X_MEM_WIDTH{1'b0}};

  assign push_tag_s.id     = bus.mem_req_id;
  assign push_tag_s.we     = bus.mem_req_we;
  assign push_tag_s.offset = bus.mem_req_addr[1:0];
  assign push_tag_s.size   = bus.mem_req_size;

  xif_mem_id_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_fifo (
    .ck      (ck),
    .rst_n   (rst_n),
    .push_i  (accept_s),
    .data_i  (push_tag_s),
    .pop_i   (pop_s),
    .data_o  (head_tag_s),
    .full_o  (full_s),
    .empty_o (empty_s)
  );

  // Next-state of the result pulse and the sticky stray-rvalid flag.
  always_comb begin
    result_valid_d = pop_s;
    stray_rvalid_d = stray_rvalid_q || (bus.ram_rvalid && empty_s);
    if (pop_s) begin
      result_id_d    = head_tag_s.id;
      result_err_d   = bus.ram_err;
      result_rdata_d = head_tag_s.we ? {X_MEM_WIDTH{1'b0}}
                                     : align_load(bus.ram_rdata, head_tag_s.offset,
                                                  head_tag_s.size);
    end else begin
      result_id_d    = {X_ID_WIDTH{1'b0}};
      result_err_d   = 1'b0;
      result_rdata_d = {X_MEM_WIDTH{1'b0}};
    end
  end

  // Result registers.
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      result_valid_q <= 1'b0;
      result_id_q    <= {X_ID_WIDTH{1'b0}};
      result_rdata_q <= {X_MEM_WIDTH{1'b0}};
      result_err_q   <= 1'b0;
      stray_rvalid_q <= 1'b0;
    end else begin
      result_valid_q <= result_valid_d;
      result_id_q    <= result_id_d;
      result_rdata_q <= result_rdata_d;
      result_err_q   <= result_err_d;
      stray_rvalid_q <= stray_rvalid_d;
    end
  end

  assign bus.mem_result_valid = result_valid_q;
  assign bus.mem_result_id    = result_id_q;
  assign bus.mem_result_rdata = result_rdata_q;
  assign bus.mem_result_err   = result_err_q;

  xif_mem_responder_chk u_chk (
    .ck             (ck),
    .rst_n          (rst_n),
    .push_i         (accept_s),
    .pop_i          (pop_s),
    .full_i         (full_s),
    .empty_i        (empty_s),
    .stray_rvalid_i (stray_rvalid_q)
  );
endmodule

// File: tb/tb_xif_mem_responder.sv
// Directed self-checking bench for xif_mem_responder (default MAX_OUTSTANDING=2).
module tb_xif_mem_responder;
  logic ck;
  logic rst_n;
  int   n_checks = 0;
  int   n_pass   = 0;

  xif_mem_responder_if #(.X_ID_WIDTH(4), .X_MEM_WIDTH(32), .ADDR_WIDTH(32)) bus ();

  xif_mem_responder dut (
    .ck    (ck),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    ck = 1'b0;
    forever #5 ck = ~ck;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge ck);
    #1;
  endtask

  task automatic req(input logic [3:0] id, input logic [31:0] addr, input logic we,
                     input logic [2:0] size, input logic [31:0] wdata);
    bus.mem_valid     = 1'b1;
    bus.mem_req_id    = id;
    bus.mem_req_addr  = addr;
    bus.mem_req_we    = we;
    bus.mem_req_size  = size;
    bus.mem_req_be    = 4'hF;
    bus.mem_req_wdata = wdata;
    #1;
  endtask

  task automatic rsp(input logic valid, input logic [31:0] rdata, input logic err);
    bus.ram_rvalid = valid;
    bus.ram_rdata  = rdata;
    bus.ram_err    = err;
    #1;
  endtask

  initial begin
    rst_n             = 1'b0;
    bus.mem_valid     = 1'b0;
    bus.mem_req_id    = 4'd0;
    bus.mem_req_addr  = 32'd0;
    bus.mem_req_we    = 1'b0;
    bus.mem_req_size  = 3'd0;
    bus.mem_req_be    = 4'h0;
    bus.mem_req_wdata = 32'd0;
    bus.ram_gnt       = 1'b0;
    bus.ram_rvalid    = 1'b0;
    bus.ram_rdata     = 32'd0;
    bus.ram_err       = 1'b0;
    step();
    check("rst_result_valid", bus.mem_result_valid, 32'd0);
    check("rst_mem_ready", bus.mem_ready, 32'd0);
    check("rst_ram_req", bus.ram_req, 32'd0);
    check("rst_exc", bus.mem_resp_exc, 32'd0);
    rst_n = 1'b1;
    step();

    // Word load, id 3
    bus.ram_gnt = 1'b1;
    req(4'd3, 32'h10, 1'b0, 3'd2, 32'd0);
    check("ld_ready", bus.mem_ready, 32'd1);
    check("ld_exc", bus.mem_resp_exc, 32'd0);
    check("ld_ram_addr", bus.ram_addr, 32'h10);
    step();
    bus.mem_valid = 1'b0;
    rsp(1'b1, 32'hDEADBEEF, 1'b0);
    check("ld_no_early_result", bus.mem_result_valid, 32'd0);
    step();
    rsp(1'b0, 32'd0, 1'b0);
    check("ld_result_valid", bus.mem_result_valid, 32'd1);
    check("ld_result_id", bus.mem_result_id, 32'd3);
    check("ld_result_rdata", bus.mem_result_rdata, 32'hDEADBEEF);
    check("ld_result_err", bus.mem_result_err, 32'd0);
    step();
    check("ld_result_pulse", bus.mem_result_valid, 32'd0);

    // Halfword load at offset 2
    req(4'd5, 32'h12, 1'b0, 3'd1, 32'd0);
    check("lh_ram_addr", bus.ram_addr, 32'h10);
    step();
    bus.mem_valid = 1'b0;
    rsp(1'b1, 32'hAABBCCDD, 1'b0);
    step();
    rsp(1'b0, 32'd0, 1'b0);
    check("lh_result_rdata", bus.mem_result_rdata, 32'h0000AABB);
    check("lh_result_id", bus.mem_result_id, 32'd5);

    // Byte load at offset 3
    req(4'd6, 32'h13, 1'b0, 3'd0, 32'd0);
    step();
    bus.mem_valid = 1'b0;
    rsp(1'b1, 32'h11223344, 1'b0);
    step();
    rsp(1'b0, 32'd0, 1'b0);
    check("lb_result_rdata", bus.mem_result_rdata, 32'h00000011);

    // Misaligned store
    req(4'd7, 32'h21, 1'b1, 3'd2, 32'h12345678);
    check("st_mis_exc", bus.mem_resp_exc, 32'd1);
    check("st_mis_code", bus.mem_resp_exccode, 32'd6);
    check("st_mis_ready", bus.mem_ready, 32'd1);
    check("st_mis_ram_req", bus.ram_req, 32'd0);
    step();
    bus.mem_valid = 1'b0;
    step();
    check("st_mis_no_result", bus.mem_result_valid, 32'd0);

    // Misaligned load, and illegal size outranking misalignment
    req(4'd1, 32'h11, 1'b0, 3'd1, 32'd0);
    check("ld_mis_code", bus.mem_resp_exccode, 32'd4);
    req(4'd1, 32'h11, 1'b0, 3'd3, 32'd0);
    check("illegal_code", bus.mem_resp_exccode, 32'd2);
    check("illegal_ram_req", bus.ram_req, 32'd0);

    // Address beyond ADDR_HI, probed with gnt low so nothing is accepted
    bus.ram_gnt = 1'b0;
    req(4'd2, 32'h0001_0000, 1'b0, 3'd2, 32'd0);
`ifdef RVFPM_MEM_RANGE_CHECK_EN
    check("range_exc", bus.mem_resp_exc, 32'd1);
    check("range_code", bus.mem_resp_exccode, 32'd5);
    check("range_ram_req", bus.ram_req, 32'd0);
`else
    check("range_exc", bus.mem_resp_exc, 32'd0);
    check("range_ram_req", bus.ram_req, 32'd1);
    check("range_ram_addr", bus.ram_addr, 32'h0001_0000);
`endif
    bus.mem_valid = 1'b0;
    bus.ram_gnt   = 1'b1;
    step();

    // Three back-to-back requests against two outstanding slots
    req(4'd1, 32'h40, 1'b0, 3'd2, 32'd0);
    check("b2b_1_ready", bus.mem_ready, 32'd1);
    step();
    req(4'd2, 32'h44, 1'b1, 3'd2, 32'hCAFEF00D);
    check("b2b_2_ready", bus.mem_ready, 32'd1);
    check("b2b_2_ram_we", bus.ram_we, 32'd1);
    check("b2b_2_wdata", bus.ram_wdata, 32'hCAFEF00D);
    step();
    req(4'd3, 32'h48, 1'b0, 3'd2, 32'd0);
    check("b2b_3_stall", bus.mem_ready, 32'd0);
    check("b2b_3_no_req", bus.ram_req, 32'd0);
    step();
    check("b2b_3_still_stall", bus.mem_ready, 32'd0);
    rsp(1'b1, 32'h00001111, 1'b0);
    check("b2b_no_bypass", bus.mem_ready, 32'd0);
    step();
    check("b2b_r1_valid", bus.mem_result_valid, 32'd1);
    check("b2b_r1_id", bus.mem_result_id, 32'd1);
    check("b2b_r1_rdata", bus.mem_result_rdata, 32'h00001111);
    check("b2b_3_ready", bus.mem_ready, 32'd1);
    rsp(1'b1, 32'h00002222, 1'b1);
    step();
    bus.mem_valid = 1'b0;
    check("b2b_r2_id", bus.mem_result_id, 32'd2);
    check("b2b_r2_store_rdata", bus.mem_result_rdata, 32'd0);
    check("b2b_r2_err", bus.mem_result_err, 32'd1);
    rsp(1'b1, 32'h00003333, 1'b0);
    step();
    rsp(1'b0, 32'd0, 1'b0);
    check("b2b_r3_id", bus.mem_result_id, 32'd3);
    check("b2b_r3_rdata", bus.mem_result_rdata, 32'h00003333);
    check("b2b_r3_err", bus.mem_result_err, 32'd0);
    step();
    check("b2b_idle", bus.mem_result_valid, 32'd0);

    // Reset with two accesses in flight, then late responses
    req(4'd8, 32'h50, 1'b0, 3'd2, 32'd0);
    step();
    req(4'd9, 32'h54, 1'b0, 3'd2, 32'd0);
    step();
    bus.mem_valid = 1'b0;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    rsp(1'b1, 32'h0000BEEF, 1'b0);
    step();
    check("rst_mid_no_result_a", bus.mem_result_valid, 32'd0);
    step();
    rsp(1'b0, 32'd0, 1'b0);
    check("rst_mid_no_result_b", bus.mem_result_valid, 32'd0);
    bus.ram_gnt = 1'b0;
    req(4'd4, 32'h60, 1'b0, 3'd2, 32'd0);
    check("rst_mid_ready_gnt0", bus.mem_ready, 32'd0);
    check("rst_mid_req_not_full", bus.ram_req, 32'd1);
    bus.ram_gnt = 1'b1;
    #1;
    check("rst_mid_ready_gnt1", bus.mem_ready, 32'd1);
    bus.mem_valid = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
